// File: rtl/rom64_lookup_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom64_lookup_arbiter_pkg
// Shared definitions for the LUT-ROM lookup arbiter:
//   - ROM_AW      : address width of a 64x1 distributed ROM slice
//   - CNT_W       : width of the settle counter (settle time 0..7)
//   - state_e     : controller state encoding (IDLE / WAIT / CAPT)
//   - clog2_min1  : ceil(log2(n)) clamped to at least 1, used to validate the
//                   requester-id width against the requester count
// -----------------------------------------------------------------------------
package rom64_lookup_arbiter_pkg;

    localparam int ROM_AW = 6;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

    // Constant function: number of bits needed to index n items, never below 1.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rom64_lookup_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Scans the request vector starting at
// position ptr_i and wrapping modulo NREQ; the first set bit wins.
//
// Ports:
//   req_i  [NREQ] : request vector
//   ptr_i  [IDW]  : index holding highest priority this round (< NREQ)
//   hit_o         : at least one request is set
//   sel_o  [NREQ] : one-hot winner (all zero when hit_o is low)
//   id_o   [IDW]  : binary index of the winner (zero when hit_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            hit_o,
    output logic [NREQ-1:0] sel_o,
    output logic [IDW-1:0]  id_o
);

    // Walk the offsets from the farthest to the nearest so that the smallest
    // offset from ptr_i that has a request is the last (and winning) write.
    always_comb begin
        hit_o = 1'b0;
        id_o  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_i[idx]) begin
                hit_o = 1'b1;
                id_o  = IDW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_sel
            assign sel_o[gi] = hit_o && (id_o == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/rom64_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// rom64_lookup_arbiter
// Shares one bank of WIDTH combinational 64x1 LUT-ROM slices among NREQ
// requesters. Round-robin arbitration, registered ROM address, programmable
// settle time, then the ROM word is captured and returned tagged with the id
// of the requester that owned the access. Only one access is ever in flight.
//
// Ports:
//   CLK       in   rising-edge clock
//   RSTN      in   asynchronous active-low reset
//   req       in   [NREQ]      request levels, held until granted
//   req_addr  in   [6*NREQ]    packed addresses, requester i at [6i+5:6i]
//   gnt       out  [NREQ]      one-hot single-cycle grant pulse
//   rom_ad    out  [6]         registered ROM address
//   rom_do    in   [WIDTH]     combinational ROM data
//   rdata     out  [WIDTH]     captured ROM word (held between pulses)
//   rvalid    out              single-cycle pulse when rdata is new
//   rid       out  [IDW]       owner of the current access / rdata
//   busy      out              controller is not idle
//
// Timing (S = SETTLE): grant edge -> rvalid edge is S+2 cycles; a requester
// served back to back sees grants S+3 cycles apart.
// -----------------------------------------------------------------------------
module rom64_lookup_arbiter
    import rom64_lookup_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter int IDW    = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [NREQ-1:0]          req,
    input  logic [ROM_AW*NREQ-1:0]   req_addr,
    output logic [NREQ-1:0]          gnt,
    output logic [ROM_AW-1:0]        rom_ad,
    input  logic [WIDTH-1:0]         rom_do,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic [IDW-1:0]           rid,
    output logic                     busy
);

    // Elaboration-time parameter sanity checks.
    generate
        if (IDW != clog2_min1(NREQ)) begin : g_bad_idw
            $error("rom64_lookup_arbiter: IDW must equal clog2(NREQ), minimum 1");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("rom64_lookup_arbiter: NREQ must be in 2..8");
        end
        if (SETTLE < 0 || SETTLE > 7) begin : g_bad_settle
            $error("rom64_lookup_arbiter: SETTLE must be in 0..7");
        end
    endgenerate

    state_e              state_q,  state_d;
    logic [IDW-1:0]      ptr_q,    ptr_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [ROM_AW-1:0]   rom_ad_q, rom_ad_d;
    logic [NREQ-1:0]     gnt_q,    gnt_d;
    logic [IDW-1:0]      rid_q,    rid_d;
    logic [WIDTH-1:0]    rdata_q,  rdata_d;
    logic                rvalid_q, rvalid_d;

    logic                pick_hit;
    logic [NREQ-1:0]     pick_sel;
    logic [IDW-1:0]      pick_id;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .hit_o (pick_hit),
        .sel_o (pick_sel),
        .id_o  (pick_id)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rom_ad_q <= '0;
            gnt_q    <= '0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rom_ad_q <= rom_ad_d;
            gnt_q    <= gnt_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rom_ad_d = rom_ad_q;
        gnt_d    = '0;       // grant and rvalid are pulses
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req and req_addr are looked at only here; anything raised
                // while an access is in flight waits for the next IDLE.
                if (pick_hit) begin
                    rom_ad_d = req_addr[int'(pick_id)*ROM_AW +: ROM_AW];
                    gnt_d    = pick_sel;
                    rid_d    = pick_id;
                    cnt_d    = CNT_W'(SETTLE);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                // ROM output is taken verbatim, unknowns included.
                rdata_d  = rom_do;
                rvalid_d = 1'b1;
                ptr_d    = (rid_q == IDW'(NREQ - 1)) ? '0 : rid_q + IDW'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign gnt    = gnt_q;
    assign rom_ad = rom_ad_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom64_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom64_lookup_arbiter
// Self-checking bench for rom64_lookup_arbiter. A behavioural ROM bank (one
// 64-bit init word per slice) drives rom_do from rom_ad. Expected grants come
// from a rotating-priority model (first requester at or after the model
// pointer), expected data from the ROM contents at the granted address.
// -----------------------------------------------------------------------------
module tb_rom64_lookup_arbiter;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int SETTLE = 1;
    localparam int IDW    = 2;
    localparam int TMO    = 40;

    logic                 CLK;
    logic                 RSTN;
    logic [NREQ-1:0]      req;
    logic [6*NREQ-1:0]    req_addr;
    logic [NREQ-1:0]      gnt;
    logic [5:0]           rom_ad;
    logic [WIDTH-1:0]     rom_do;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic [IDW-1:0]       rid;
    logic                 busy;

    logic [63:0]          rom_init [WIDTH];
    logic                 x_mode;

    int n_cmp;
    int n_err;
    int cyc;
    int m_ptr;

    rom64_lookup_arbiter #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE),
        .IDW    (IDW)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_ad   (rom_ad),
        .rom_do   (rom_do),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rid      (rid),
        .busy     (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural ROM bank: slice b returns bit rom_ad of its init word.
    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            rom_do[b] = rom_init[b][rom_ad];
        end
        if (x_mode) begin
            rom_do = 'x;
        end
    end

    function automatic logic [WIDTH-1:0] rom_word(input logic [5:0] a);
        logic [WIDTH-1:0] w;
        for (int b = 0; b < WIDTH; b++) begin
            w[b] = rom_init[b][a];
        end
        return w;
    endfunction

    // Round-robin reference: first requester at or after p, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [5:0] addr_of(input logic [6*NREQ-1:0] v, input int i);
        return v[i*6 +: 6];
    endfunction

    task automatic set_all_init(input logic [63:0] v);
        for (int b = 0; b < WIDTH; b++) rom_init[b] = v;
    endtask

    task automatic rand_init();
        for (int b = 0; b < WIDTH; b++) rom_init[b] = {$urandom, $urandom};
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge CLK); #1;
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(posedge CLK); #1;
            if (rvalid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        RSTN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({gnt, rom_ad, rdata, rvalid, rid, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b ad=%0d rdata=%h rv=%b rid=%0d busy=%b, want all zero",
                     gnt, rom_ad, rdata, rvalid, rid, busy);
        end
        RSTN  = 1'b1;
        m_ptr = 0;
        $display("reset: outputs checked, released");
    endtask

    task automatic test_all_four();
        bit ok;
        int exp_id;
        int last;
        rand_init();
        req_addr = {6'd3, 6'd2, 6'd1, 6'd0};
        req = 4'b1111;
        last = 0;
        for (int i = 0; i < 5; i++) begin
            exp_id = model_pick(req, m_ptr);
            wait_gnt(ok);
            n_cmp++;
            if (!ok || gnt !== NREQ'(1 << exp_id)) begin
                n_err++;
                $display("FAIL all4_gnt[%0d]: got %b, want %b", i, gnt, NREQ'(1 << exp_id));
            end
            if (i > 0) begin
                n_cmp++;
                if (cyc - last != SETTLE + 3) begin
                    n_err++;
                    $display("FAIL all4_interval[%0d]: got %0d cycles, want %0d", i, cyc - last, SETTLE + 3);
                end
            end
            last = cyc;
            if (i == 4) req = '0;
            wait_rvalid(ok);
            n_cmp++;
            if (!ok || rdata !== rom_word(6'(exp_id)) || rid !== IDW'(exp_id)) begin
                n_err++;
                $display("FAIL all4_data[%0d]: got rdata=%h rid=%0d, want %h rid=%0d",
                         i, rdata, rid, rom_word(6'(exp_id)), exp_id);
            end
            m_ptr = (exp_id + 1) % NREQ;
            $display("all4: grant %0d -> id %0d rdata=%h", i, exp_id, rdata);
        end
    endtask

    task automatic test_single();
        bit ok;
        int t0;
        logic [63:0] iv;
        iv = 64'hF0F0_A5A5_0123_CDEF;
        set_all_init(iv);
        req_addr = '0;
        req_addr[6 +: 6] = 6'd5;
        req = 4'b0010;
        wait_gnt(ok);
        t0 = cyc;
        n_cmp++;
        if (!ok || gnt !== 4'b0010 || rom_ad !== 6'd5 || rid !== 2'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b ad=%0d rid=%0d busy=%b, want 0010/5/1/1",
                     gnt, rom_ad, rid, busy);
        end
        req = '0;
        @(posedge CLK); #1;
        n_cmp++;
        if (gnt !== '0 || rom_ad !== 6'd5) begin
            n_err++;
            $display("FAIL single_gnt_pulse: got gnt=%b ad=%0d, want 0000/5", gnt, rom_ad);
        end
        wait_rvalid(ok);
        n_cmp++;
        if (!ok || cyc - t0 != SETTLE + 2) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles, want %0d", cyc - t0, SETTLE + 2);
        end
        n_cmp++;
        if (rdata !== {WIDTH{iv[5]}} || rid !== 2'd1) begin
            n_err++;
            $display("FAIL single_data: got rdata=%h rid=%0d, want %h rid=1", rdata, rid, {WIDTH{iv[5]}});
        end
        m_ptr = 2;
        @(posedge CLK); #1;
        n_cmp++;
        if (rvalid !== 1'b0 || rdata !== {WIDTH{iv[5]}} || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_hold: got rv=%b rdata=%h busy=%b, want 0/%h/0", rvalid, rdata, {WIDTH{iv[5]}}, busy);
        end
        $display("single: id 1 addr 5 rdata=%h", rdata);
    endtask

    task automatic test_wrap();
        bit ok;
        int exp_id;
        set_all_init(64'hF0F0_A5A5_0123_CDEF);
        req_addr = {6'd40, 6'd33, 6'd20, 6'd7};
        // Serve requester 2 so that priority next starts at requester 3.
        req = 4'b0100;
        exp_id = model_pick(req, m_ptr);
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== NREQ'(1 << exp_id)) begin
            n_err++;
            $display("FAIL wrap_setup: got %b, want %b", gnt, NREQ'(1 << exp_id));
        end
        req = '0;
        wait_rvalid(ok);
        m_ptr = (exp_id + 1) % NREQ;
        req = 4'b0101;
        exp_id = model_pick(req, m_ptr);
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== NREQ'(1 << exp_id) || rom_ad !== addr_of(req_addr, exp_id)) begin
            n_err++;
            $display("FAIL wrap_first: got gnt=%b ad=%0d, want %b ad=%0d",
                     gnt, rom_ad, NREQ'(1 << exp_id), addr_of(req_addr, exp_id));
        end
        req = 4'b0100;
        wait_rvalid(ok);
        m_ptr = (exp_id + 1) % NREQ;
        exp_id = model_pick(req, m_ptr);
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== NREQ'(1 << exp_id)) begin
            n_err++;
            $display("FAIL wrap_second: got %b, want %b", gnt, NREQ'(1 << exp_id));
        end
        req = '0;
        wait_rvalid(ok);
        n_cmp++;
        if (!ok || rdata !== rom_word(addr_of(req_addr, exp_id)) || rid !== IDW'(exp_id)) begin
            n_err++;
            $display("FAIL wrap_data: got rdata=%h rid=%0d, want %h rid=%0d",
                     rdata, rid, rom_word(addr_of(req_addr, exp_id)), exp_id);
        end
        m_ptr = (exp_id + 1) % NREQ;
        $display("wrap: second grant id %0d", exp_id);
    endtask

    task automatic test_edges();
        bit ok;
        int exp_id;
        logic [5:0] ea;
        set_all_init(64'h8000_0000_0000_0001);
        for (int i = 0; i < 2; i++) begin
            ea = (i == 0) ? 6'd0 : 6'd63;
            req_addr = {NREQ{ea}};
            req = 4'b1111;
            exp_id = model_pick(req, m_ptr);
            wait_gnt(ok);
            req = '0;
            wait_rvalid(ok);
            n_cmp++;
            if (!ok || rdata !== {WIDTH{1'b1}} || rid !== IDW'(exp_id)) begin
                n_err++;
                $display("FAIL edge_addr_%0d: got rdata=%h rid=%0d, want %h rid=%0d",
                         ea, rdata, rid, {WIDTH{1'b1}}, exp_id);
            end
            m_ptr = (exp_id + 1) % NREQ;
            $display("edge: addr %0d rdata=%h", ea, rdata);
        end
    endtask

    task automatic test_late_req();
        bit ok;
        int exp_id;
        rand_init();
        req_addr = {6'd11, 6'd22, 6'd33, 6'd44};
        req = NREQ'(1 << m_ptr);
        exp_id = m_ptr;
        wait_gnt(ok);
        req = '0;
        repeat (SETTLE + 1) @(posedge CLK);
        #1;
        // Controller is in its capture state now; raise a new request.
        req = 4'b1000;
        n_cmp++;
        if (rvalid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL late_capt_state: got rv=%b busy=%b, want 0/1", rvalid, busy);
        end
        @(posedge CLK); #1;
        n_cmp++;
        if (rvalid !== 1'b1 || gnt !== '0 || rdata !== rom_word(addr_of(req_addr, exp_id))) begin
            n_err++;
            $display("FAIL late_no_early_gnt: got rv=%b gnt=%b rdata=%h, want 1/0000/%h",
                     rvalid, gnt, rdata, rom_word(addr_of(req_addr, exp_id)));
        end
        m_ptr = (exp_id + 1) % NREQ;
        exp_id = model_pick(req, m_ptr);
        @(posedge CLK); #1;
        n_cmp++;
        if (gnt !== NREQ'(1 << exp_id)) begin
            n_err++;
            $display("FAIL late_gnt: got %b, want %b", gnt, NREQ'(1 << exp_id));
        end
        req = '0;
        wait_rvalid(ok);
        m_ptr = (exp_id + 1) % NREQ;
        $display("late: request raised in capture granted to id %0d", exp_id);
    endtask

    task automatic test_x_passthrough();
        bit ok;
        logic [WIDTH-1:0] exp_w;
        x_mode = 1'b1;
        req_addr = {6'd9, 6'd9, 6'd9, 6'd9};
        req = 4'b1111;
        wait_gnt(ok);
        m_ptr = (model_pick(req, m_ptr) + 1) % NREQ;
        req = '0;
        repeat (SETTLE + 1) @(posedge CLK);
        #1;
        exp_w = rom_do;  // value the bench's ROM presents during capture
        wait_rvalid(ok);
        n_cmp++;
        if (!ok || rvalid !== 1'b1 || rdata !== exp_w) begin
            n_err++;
            $display("FAIL x_capture: got rv=%b rdata=%h, want 1/%h", rvalid, rdata, exp_w);
        end
        x_mode = 1'b0;
        $display("xprop: rdata=%h", rdata);
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_all_init(64'hF0F0_A5A5_0123_CDEF);
        req_addr = {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom)};
        req = 4'b0100;
        wait_gnt(ok);
        req = '0;
        @(posedge CLK); #1;
        RSTN = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, rom_ad, rdata, rvalid, rid, busy} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got gnt=%b ad=%0d rdata=%h rv=%b rid=%0d busy=%b, want all zero",
                     gnt, rom_ad, rdata, rvalid, rid, busy);
        end
        for (int i = 0; i < SETTLE + 3; i++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if (rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_no_rvalid[%0d]: got %b, want 0", i, rvalid);
            end
        end
        RSTN  = 1'b1;
        m_ptr = 0;
        req   = 4'b1111;
        wait_gnt(ok);
        n_cmp++;
        if (!ok || gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL midreset_first_gnt: got %b, want 0001", gnt);
        end
        req = '0;
        wait_rvalid(ok);
        n_cmp++;
        if (!ok || rdata !== rom_word(addr_of(req_addr, 0)) || rid !== '0) begin
            n_err++;
            $display("FAIL midreset_data: got rdata=%h rid=%0d, want %h rid=0",
                     rdata, rid, rom_word(addr_of(req_addr, 0)));
        end
        m_ptr = 1;
        $display("midreset: aborted access, next grant to id 0");
    endtask

    task automatic test_random();
        bit ok;
        int exp_id;
        logic [5:0] ea;
        for (int t = 0; t < 40; t++) begin
            rand_init();
            req_addr = {$urandom, $urandom};
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            exp_id = model_pick(req, m_ptr);
            ea = addr_of(req_addr, exp_id);
            wait_gnt(ok);
            n_cmp++;
            if (!ok || gnt !== NREQ'(1 << exp_id) || rom_ad !== ea) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got gnt=%b ad=%0d, want %b ad=%0d",
                         t, gnt, rom_ad, NREQ'(1 << exp_id), ea);
            end
            // Addresses change after the decision; the access must not notice.
            req = '0;
            req_addr = {$urandom, $urandom};
            wait_rvalid(ok);
            n_cmp++;
            if (!ok || rdata !== rom_word(ea) || rid !== IDW'(exp_id)) begin
                n_err++;
                $display("FAIL rand_data[%0d]: got rdata=%h rid=%0d, want %h rid=%0d",
                         t, rdata, rid, rom_word(ea), exp_id);
            end
            m_ptr = (exp_id + 1) % NREQ;
            $display("rand %0d: id %0d addr %0d rdata=%h", t, exp_id, ea, rdata);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_ptr    = 0;
        RSTN     = 1'b0;
        req      = '0;
        req_addr = '0;
        x_mode   = 1'b0;
        set_all_init(64'h0);

        test_reset();
        test_all_four();
        test_single();
        test_wrap();
        test_edges();
        test_late_req();
        test_x_passthrough();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom64_lookup_arbiter.md
Name: rom64_lookup_arbiter

Overview:
- Shares one bank of WIDTH distributed 64x1 LUT ROM slices among NREQ independent requesters.
- The slices are combinational: they share a 6-bit address and each returns one bit.
- The block arbitrates round-robin, drives a registered ROM address, waits a programmable settle time, then captures the ROM word and returns it tagged with the requester id.
- It sits between the LUT-ROM datapath and client engines such as coefficient fetch or CRC table lookup.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, ROM word width, i.e. the number of 64x1 slices in the bank.
- SETTLE, 1, extra cycles the address is held before data capture (0..7).
- IDW, 2, requester-id width; must equal clog2(NREQ), minimum 1.

Ports:
- CLK  in  1  rising-edge clock.
- RSTN  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until granted.
- req_addr  in  6*NREQ  packed addresses; requester i uses bits [6i+5:6i].
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- rom_ad  out  6  registered address to the ROM bank (AD5..AD0).
- rom_do  in  WIDTH  combinational ROM data.
- rdata  out  WIDTH  captured ROM word.
- rvalid  out  1  one-cycle pulse when rdata is valid.
- rid  out  IDW  id of the requester that owns rdata.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (RSTN low, asynchronous) clears everything to zero: gnt, rom_ad, rdata, rvalid, rid, busy, round-robin pointer (priority starts at requester 0), settle counter; state goes to IDLE.
- While RSTN is low, all outputs are held at these values.
- Reset deassertion is sampled synchronously; the first arbitration happens on the first rising edge with RSTN high.
- State machine:
  - IDLE: if any req is set, pick the first set bit at or after ptr (wrapping modulo NREQ). Register rom_ad <= that requester's address, pulse its gnt, set rid, load cnt <= SETTLE, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if cnt == 0 go to CAPT, else decrement cnt. rom_ad is stable throughout.
  - CAPT: rdata <= rom_do, pulse rvalid, set ptr <= (granted id + 1) mod NREQ, go to IDLE.
- Latency and throughput:
  - Grant to rvalid is SETTLE+2 cycles.
  - Back-to-back service of one requester takes SETTLE+3 cycles per access.
  - Only one access is ever outstanding.
- gnt is asserted in the cycle following the IDLE decision edge, for one cycle only. Requesters drop or advance req on seeing gnt. req_addr is sampled only at the IDLE decision edge; later changes have no effect.
- rdata holds its last value between rvalid pulses. rid holds until the next grant.
- Boundary conditions:
  - Simultaneous requests: exactly one grant per arbitration, with rotating priority. NREQ requesters held permanently active are each served exactly once per NREQ accesses.
  - A requester that deasserts req before being granted is simply skipped, with no error.
  - req asserted during WAIT or CAPT is not observed until the next IDLE.
  - With SETTLE = 0, WAIT lasts one cycle.
  - X/Z on rom_do is captured unchanged into rdata. There is no masking, so X-propagation from the ROM model stays visible.
  - Reset mid-access aborts it with no rvalid. ptr returns to 0.

Decomposition:
- Shared package:
  - State encoding constants: IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2.
  - ROM_AW = 6.
  - A clog2 constant function used for the IDW check.
- One natural sub-module: rr_pick.
  - Combinational rotating-priority picker.
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: hit, one-hot sel[NREQ], id[IDW].
  - Reused by other arbiters in the library.
- Top level holds the FSM, settle counter, address and data registers.

Test Plan:
- Reset mid-access: with the ROM initval = 64'hF0F0_A5A5_0123_CDEF (all slices), assert RSTN low during WAIT -> all outputs 0 immediately, no rvalid, next grant goes to requester 0.
- Single requester: req[1] = 1, addr = 6'd5, SETTLE = 1 -> gnt = 4'b0010 one cycle, rom_ad = 5, rvalid 3 cycles after gnt, rdata = slice bit 5 replicated, rid = 1.
- All four requesters held active, addresses 0, 1, 2, 3 -> grant order 0, 1, 2, 3, 0 with SETTLE+3 cycles between grants; each rvalid matches its requester's ROM bit.
- Wrap case: ptr = 3, requests req = 4'b0101 -> requester 0 is granted, then requester 2; requester 3 is not granted.
- Edge addresses: addresses 6'd0 and 6'd63 with initval = 64'h8000_0000_0000_0001 -> rdata all-ones for both.
- X propagation and late requests:
  - rom_do driven to X -> rdata is X and rvalid is still 1.
  - req raised during CAPT is granted on the cycle after IDLE resumes.
